display_scheduler: RTL and testbench

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

---
 rtl/display_scheduler_pkg.sv | 32 +++
 rtl/display_scheduler_hex_to_7seg.sv | 11 +
 rtl/display_scheduler.sv | 107 ++++++++++
 tb/tb_display_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_scheduler_pkg.sv
// Shared constants and types for the multiplexed 8-digit 7-segment display scheduler.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package display_scheduler_pkg;

  localparam int DIGITS = 8;
  localparam int PHASES = 8;

  localparam logic [7:0] ANODE_OFF = 8'hFF;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  // Index 15 is leftmost, so the list reads F down to 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic       valid;
    logic [2:0] addr;
    logic [3:0] data;
  } wr_req_t;

  typedef struct packed {
    logic [DIGITS-1:0] mask;
    logic [2:0]        bright;
  } disp_cfg_t;

  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/display_scheduler_hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment lookup.
module hex_to_7seg
  import display_scheduler_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = seg_code(hex);

endmodule

// File: rtl/display_scheduler.sv
// Time-multiplexed 8-digit display scan with PWM brightness and frame-aligned,
// tear-free commit of host-written shadow digits and configuration.
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int PHASE_DIV = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [2:0]        wr_addr,
  input  logic [3:0]        wr_data,
  input  logic [DIGITS-1:0] cfg_mask,
  input  logic [2:0]        cfg_bright,
  input  logic              commit_req,
  output logic              commit_pending,
  output logic              frame_start,
  output logic [DIGITS-1:0] Anode,
  output logic [6:0]        Cathode
);

  localparam int            PW      = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PHASE_DIV - 1);

  // Scan counters
  logic [PW-1:0] prescaler;
  logic [2:0]    phase, digit;
  logic          pre_wrap, phase_wrap, frame_end;

  assign pre_wrap   = (prescaler == PRE_MAX);
  assign phase_wrap = pre_wrap && (phase == 3'(PHASES - 1));
  assign frame_end  = phase_wrap && (digit == 3'(DIGITS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler   <= '0;
      phase       <= '0;
      digit       <= '0;
      frame_start <= 1'b0;
    end else begin
      prescaler   <= pre_wrap ? '0 : prescaler + 1'b1;
      if (pre_wrap)   phase <= phase + 1'b1;
      if (phase_wrap) digit <= digit + 1'b1;
      // Counters read all-zero in the cycle after the frame boundary.
      frame_start <= frame_end;
    end
  end

  // Host write path into shadow storage
  wr_req_t                  wr;
  logic                     wr_fire;
  logic [DIGITS-1:0][3:0]   shadow, active;
  disp_cfg_t                act_cfg;

  assign wr       = '{valid: wr_valid, addr: wr_addr, data: wr_data};
  assign wr_ready = !commit_pending;
  assign wr_fire  = wr.valid && wr_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        shadow <= '0;
    else if (wr_fire) shadow[wr.addr] <= wr.data;
  end

  // A request seen on the boundary cycle itself only arms the flag, so it
  // lands one frame later instead of racing the copy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      commit_pending <= 1'b0;
      active         <= '0;
      act_cfg        <= '0;
    end else if (frame_end && commit_pending) begin
      active         <= shadow;
      act_cfg        <= '{mask: cfg_mask, bright: cfg_bright};
      commit_pending <= 1'b0;
    end else if (commit_req && !commit_pending) begin
      commit_pending <= 1'b1;
    end
  end

  // Output stage
  logic              lit;
  logic [DIGITS-1:0] sel;
  logic [6:0]        seg;

  assign lit = act_cfg.mask[digit] && (phase <= act_cfg.bright);

  for (genvar g = 0; g < DIGITS; g++) begin : g_sel
    assign sel[g] = lit && (digit == 3'(g));
  end

  hex_to_7seg u_seg (
    .hex (active[digit]),
    .seg (seg)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Anode   <= ANODE_OFF;
      Cathode <= SEG_OFF;
    end else begin
      Anode   <= ~sel;
      Cathode <= lit ? seg : SEG_OFF;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler at PHASE_DIV=2 (16-clock slots, 128-clock frames).
module tb_display_scheduler;

  logic       clock, reset;
  logic       wr_valid, wr_ready;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [7:0] cfg_mask;
  logic [2:0] cfg_bright;
  logic       commit_req, commit_pending, frame_start;
  logic [7:0] Anode;
  logic [6:0] Cathode;

  display_scheduler #(.PHASE_DIV(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .cfg_mask       (cfg_mask),
    .cfg_bright     (cfg_bright),
    .commit_req     (commit_req),
    .commit_pending (commit_pending),
    .frame_start    (frame_start),
    .Anode          (Anode),
    .Cathode        (Cathode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] mask;
    logic [2:0] bright;
    int         off;
    logic [7:0] an;
    logic [6:0] ca;
  } vec_t;

  vec_t vecs[25];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_frame();
    int k;
    step();
    k = 1;
    while (!frame_start && k < 300) begin
      step();
      k++;
    end
    chk("frame_start_seen", 32'(frame_start), 32'd1);
  endtask

  task automatic wait_applied();
    int k;
    k = 0;
    while (commit_pending && k < 300) begin
      step();
      k++;
    end
    chk("commit_applied", 32'(commit_pending), 32'd0);
    chk("apply_on_frame_start", 32'(frame_start), 32'd1);
  endtask

  task automatic pulse_commit();
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
  endtask

  task automatic write(input logic [2:0] a, input logic [3:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    int n, cnt_fe, cnt_bad;
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    cfg_mask = '0; cfg_bright = '0; commit_req = 1'b0;

    // Reset state
    #12;
    chk("rst_anode", 32'(Anode), 32'hFF);
    chk("rst_cathode", 32'(Cathode), 32'h7F);
    chk("rst_pending", 32'(commit_pending), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    #1 reset = 1'b0;

    // Two blank frames, frame_start every 128 clocks starting 128 after release
    for (int k = 1; k <= 256; k++) begin
      step();
      chk("idle_frame_start", 32'(frame_start), 32'((k % 128) == 0));
      chk("idle_anode", 32'(Anode), 32'hFF);
      chk("idle_cathode", 32'(Cathode), 32'h7F);
    end

    for (int i = 0; i < 8; i++) write(3'(i), 4'(i + 1));

    n = 0;
    vecs[n++] = '{8'hFF, 3'd7,   1, 8'hFE, 7'h79};
    vecs[n++] = '{8'hFF, 3'd7,  16, 8'hFE, 7'h79};
    vecs[n++] = '{8'hFF, 3'd7,  17, 8'hFD, 7'h24};
    vecs[n++] = '{8'hFF, 3'd7,  40, 8'hFB, 7'h30};
    vecs[n++] = '{8'hFF, 3'd7,  60, 8'hF7, 7'h19};
    vecs[n++] = '{8'hFF, 3'd7,  70, 8'hEF, 7'h12};
    vecs[n++] = '{8'hFF, 3'd7,  90, 8'hDF, 7'h02};
    vecs[n++] = '{8'hFF, 3'd7, 100, 8'hBF, 7'h78};
    vecs[n++] = '{8'hFF, 3'd7, 127, 8'h7F, 7'h00};
    vecs[n++] = '{8'hFF, 3'd7,   0, 8'h7F, 7'h00};
    vecs[n++] = '{8'h01, 3'd0,   1, 8'hFE, 7'h79};
    vecs[n++] = '{8'h01, 3'd0,   2, 8'hFE, 7'h79};
    vecs[n++] = '{8'h01, 3'd0,   3, 8'hFF, 7'h7F};
    vecs[n++] = '{8'h01, 3'd0,   0, 8'hFF, 7'h7F};
    vecs[n++] = '{8'h01, 3'd0,  17, 8'hFF, 7'h7F};
    vecs[n++] = '{8'hA5, 3'd3,   1, 8'hFE, 7'h79};
    vecs[n++] = '{8'hA5, 3'd3,   8, 8'hFE, 7'h79};
    vecs[n++] = '{8'hA5, 3'd3,   9, 8'hFF, 7'h7F};
    vecs[n++] = '{8'hA5, 3'd3,  17, 8'hFF, 7'h7F};
    vecs[n++] = '{8'hA5, 3'd3,  33, 8'hFB, 7'h30};
    vecs[n++] = '{8'hA5, 3'd3,  81, 8'hDF, 7'h02};
    vecs[n++] = '{8'hA5, 3'd3, 113, 8'h7F, 7'h00};
    vecs[n++] = '{8'hA5, 3'd3, 121, 8'hFF, 7'h7F};
    vecs[n++] = '{8'h00, 3'd7,   1, 8'hFF, 7'h7F};
    vecs[n++] = '{8'h00, 3'd7,  64, 8'hFF, 7'h7F};

    for (int i = 0; i < n; i++) begin
      if (i == 0 || vecs[i].mask != vecs[i-1].mask || vecs[i].bright != vecs[i-1].bright) begin
        cfg_mask = vecs[i].mask; cfg_bright = vecs[i].bright;
        pulse_commit();
        wait_applied();
      end else begin
        wait_frame();
      end
      repeat (vecs[i].off) step();
      chk($sformatf("vec%0d_anode", i), 32'(Anode), 32'(vecs[i].an));
      chk($sformatf("vec%0d_cathode", i), 32'(Cathode), 32'(vecs[i].ca));
    end

    // 1/8 duty on digit 0 only: exactly 2 lit clocks per frame
    cfg_mask = 8'h01; cfg_bright = 3'd0;
    pulse_commit();
    wait_applied();
    cnt_fe = 0; cnt_bad = 0;
    for (int k = 0; k < 128; k++) begin
      if (Anode == 8'hFE) cnt_fe++;
      else if (Anode != 8'hFF) cnt_bad++;
      if (k < 127) step();
    end
    chk("duty_lit_count", 32'(cnt_fe), 32'd2);
    chk("duty_other_count", 32'(cnt_bad), 32'd0);

    // Write while pending is refused
    cfg_mask = 8'hFF; cfg_bright = 3'd7;
    pulse_commit();
    wait_applied();
    pulse_commit();
    chk("pend_set", 32'(commit_pending), 32'd1);
    chk("pend_wr_ready", 32'(wr_ready), 32'd0);
    write(3'd0, 4'hF);
    chk("pend_digit0_unchanged", 32'(Cathode), 32'h79);
    wait_applied();
    chk("wr_ready_after_boundary", 32'(wr_ready), 32'd1);
    step();
    chk("blocked_write_anode", 32'(Anode), 32'hFE);
    chk("blocked_write_cathode", 32'(Cathode), 32'h79);

    // Write accepted alongside the commit is included
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 4'hA; commit_req = 1'b1;
    step();
    wr_valid = 1'b0; commit_req = 1'b0;
    wait_applied();
    step();
    chk("same_cycle_write_cathode", 32'(Cathode), 32'h08);

    // Commit on the boundary cycle lands one frame later
    write(3'd0, 4'hC);
    wait_frame();
    repeat (127) step();
    chk("boundary_cycle_not_frame_start", 32'(frame_start), 32'd0);
    pulse_commit();
    chk("boundary_frame_start", 32'(frame_start), 32'd1);
    chk("boundary_still_pending", 32'(commit_pending), 32'd1);
    step();
    chk("boundary_old_data", 32'(Cathode), 32'h08);
    wait_applied();
    step();
    chk("boundary_new_data", 32'(Cathode), 32'h46);

    // Reset mid-frame with a commit pending
    pulse_commit();
    chk("mid_pending", 32'(commit_pending), 32'd1);
    repeat (4) step();
    chk("mid_lit_anode", 32'(Anode), 32'hFE);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_anode", 32'(Anode), 32'hFF);
    chk("mid_rst_cathode", 32'(Cathode), 32'h7F);
    chk("mid_rst_pending", 32'(commit_pending), 32'd0);
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
    #2 reset = 1'b0;
    cnt_bad = 0;
    for (int k = 1; k <= 128; k++) begin
      step();
      if (Anode != 8'hFF) cnt_bad++;
      if (k < 128) chk("post_rst_no_frame_start", 32'(frame_start), 32'd0);
    end
    chk("post_rst_frame_start", 32'(frame_start), 32'd1);
    chk("post_rst_blank", 32'(cnt_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
